// File: rtl/puf_host_pkg.sv
// Shared types and defaults for the PUF host controller.
// The majority-vote build (PUF_MAJORITY_VOTE_EN) uses majority3.
package puf_host_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } puf_state_e;

    localparam int unsigned DEF_RESET_CYCLES   = 32'd4;
    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'h0100_0000;

    function automatic logic [7:0] majority3(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/puf_host_ctrl_done_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF done flag into the clk domain.
module puf_done_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/puf_host_ctrl.sv
// Host-side sequencer for one PUF evaluation: clear, run with timeout, capture, respond.
// Define PUF_MAJORITY_VOTE_EN to run three passes per request and return their bitwise majority.
module puf_host_ctrl
    import puf_host_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [7:0] req_challenge,
    output logic       req_ready,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err,
    input  logic       resp_ready,
    output logic       puf_enable,
    output logic [7:0] puf_challenge,
    output logic       puf_reset,
    input  logic       puf_done,
    input  logic [7:0] puf_response
);

    localparam logic [7:0]  CLR_LAST   = 8'(RESET_CYCLES - 32'd1);
    localparam logic [31:0] TIMER_LAST = TIMEOUT_CYCLES - 32'd1;

    puf_state_e  r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [7:0]  r_resp_data;
    logic        r_resp_err;
    logic        r_puf_enable;
    logic        r_puf_reset;
    logic [7:0]  r_puf_challenge;
    logic [7:0]  r_clr_cnt;
    logic [31:0] r_timer;
    logic        w_done_sync;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]  r_pass;
    logic [7:0]  r_vote0;
    logic [7:0]  r_vote1;
`endif

    puf_done_sync u_done_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (puf_done),
        .o_sync  (w_done_sync)
    );

    // Evaluation sequencer; every output is a register updated here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= 8'h00;
            r_resp_err      <= 1'b0;
            r_puf_enable    <= 1'b0;
            r_puf_reset     <= 1'b1;
            r_puf_challenge <= 8'h00;
            r_clr_cnt       <= 8'd0;
            r_timer         <= 32'd0;
`ifdef PUF_MAJORITY_VOTE_EN
            r_pass          <= 2'd0;
            r_vote0         <= 8'h00;
            r_vote1         <= 8'h00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_puf_enable <= 1'b0;
                    r_puf_reset  <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_puf_challenge <= req_challenge;
                        r_req_ready     <= 1'b0;
                        r_clr_cnt       <= 8'd0;
`ifdef PUF_MAJORITY_VOTE_EN
                        r_pass          <= 2'd0;
`endif
                        r_state         <= CLEAR;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_puf_reset  <= 1'b0;
                        r_puf_enable <= 1'b1;
                        r_timer      <= 32'd0;
                        r_state      <= RUN;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 8'd1;
                    end
                end
                RUN: begin
                    // The first RUN cycle may still see the previous pass's done in the synchronizer
                    if (w_done_sync && (r_timer != 32'd0)) begin
                        r_puf_enable <= 1'b0;
                        r_state      <= CAPTURE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_puf_enable <= 1'b0;
                        r_puf_reset  <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_data  <= 8'h00;
                        r_state      <= RESP;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                CAPTURE: begin
                    r_puf_enable <= 1'b0;
                    r_puf_reset  <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                    if (r_pass == 2'd2) begin
                        r_resp_data  <= majority3(r_vote0, r_vote1, puf_response);
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        if (r_pass == 2'd0) begin
                            r_vote0 <= puf_response;
                        end else begin
                            r_vote1 <= puf_response;
                        end
                        r_pass    <= r_pass + 2'd1;
                        r_clr_cnt <= 8'd0;
                        r_state   <= CLEAR;
                    end
`else
                    r_resp_data  <= puf_response;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_resp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_puf_enable <= 1'b0;
                    r_puf_reset  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_err      = r_resp_err;
    assign puf_enable    = r_puf_enable;
    assign puf_reset     = r_puf_reset;
    assign puf_challenge = r_puf_challenge;

endmodule

// File: tb/tb_puf_host_ctrl.sv
// Self-checking bench for puf_host_ctrl: instance a uses the default timeout, instance b TIMEOUT_CYCLES=50.
// Build with PUF_MAJORITY_VOTE_EN to exercise the three-pass majority variant.
module tb_puf_host_ctrl;

    localparam int unsigned TO_B  = 32'd50;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] req_challenge = 8'h00;
    logic       resp_ready = 1'b0;
    logic       a_req_valid = 1'b0, b_req_valid = 1'b0;

    logic       a_req_ready, a_resp_valid, a_resp_err, a_puf_enable, a_puf_reset;
    logic [7:0] a_resp_data, a_puf_challenge;
    logic       b_req_ready, b_resp_valid, b_resp_err, b_puf_enable, b_puf_reset;
    logic [7:0] b_resp_data, b_puf_challenge;
    logic       a_puf_done = 1'b0, b_puf_done = 1'b0;
    logic [7:0] a_puf_response = 8'h00, b_puf_response = 8'h00;

    int checks = 0;
    int errors = 0;

    puf_host_ctrl u_dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(a_req_valid), .req_challenge(req_challenge),
        .req_ready(a_req_ready), .resp_valid(a_resp_valid), .resp_data(a_resp_data),
        .resp_err(a_resp_err), .resp_ready(resp_ready), .puf_enable(a_puf_enable),
        .puf_challenge(a_puf_challenge), .puf_reset(a_puf_reset), .puf_done(a_puf_done),
        .puf_response(a_puf_response)
    );

    puf_host_ctrl #(.RESET_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd50)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(b_req_valid), .req_challenge(req_challenge),
        .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
        .resp_err(b_resp_err), .resp_ready(resp_ready), .puf_enable(b_puf_enable),
        .puf_challenge(b_puf_challenge), .puf_reset(b_puf_reset), .puf_done(b_puf_done),
        .puf_response(b_puf_response)
    );

    // PUF models: done rises dly enable-cycles after enable, response per pass, cleared by puf_reset
    int unsigned a_dly = NEVER, b_dly = NEVER;
    int unsigned a_cnt = 0, b_cnt = 0, a_pass = 0, b_pass = 0;
    logic [7:0]  a_rsp [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0]  b_rsp [3] = '{8'h00, 8'h00, 8'h00};
    logic        a_en_q = 1'b0, b_en_q = 1'b0;

    always @(negedge clk) begin
        if (a_puf_reset) begin
            a_puf_done = 1'b0; a_puf_response = 8'h00; a_cnt = 0;
        end else if (a_puf_enable) begin
            if (a_cnt == a_dly) begin a_puf_done = 1'b1; a_puf_response = a_rsp[a_pass]; end
            a_cnt++;
        end
        if (a_en_q && !a_puf_enable) a_pass = (a_pass + 1) % 3;
        a_en_q = a_puf_enable;
        if (b_puf_reset) begin
            b_puf_done = 1'b0; b_puf_response = 8'h00; b_cnt = 0;
        end else if (b_puf_enable) begin
            if (b_cnt == b_dly) begin b_puf_done = 1'b1; b_puf_response = b_rsp[b_pass]; end
            b_cnt++;
        end
        if (b_en_q && !b_puf_enable) b_pass = (b_pass + 1) % 3;
        b_en_q = b_puf_enable;
    end

    bit sel = 1'b0;
    logic       o_req_ready, o_resp_valid, o_resp_err, o_puf_enable, o_puf_reset;
    logic [7:0] o_resp_data, o_puf_challenge;
    assign o_req_ready     = sel ? b_req_ready     : a_req_ready;
    assign o_resp_valid    = sel ? b_resp_valid    : a_resp_valid;
    assign o_resp_err      = sel ? b_resp_err      : a_resp_err;
    assign o_resp_data     = sel ? b_resp_data     : a_resp_data;
    assign o_puf_enable    = sel ? b_puf_enable    : a_puf_enable;
    assign o_puf_reset     = sel ? b_puf_reset     : a_puf_reset;
    assign o_puf_challenge = sel ? b_puf_challenge : a_puf_challenge;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned PASSES = 3;
`else
    localparam int unsigned PASSES = 1;
`endif

    // Reference: done seen through 2 sync flops wins if it lands no later than the last timer cycle
    function automatic bit ref_ok(input int unsigned dly, input int unsigned tmo);
        return (dly <= tmo - 3);
    endfunction

    function automatic int unsigned ref_run_len(input int unsigned dly, input int unsigned tmo);
        return ref_ok(dly, tmo) ? PASSES * (dly + 3) : tmo;
    endfunction

    function automatic logic [8:0] ref_result(input int unsigned dly, input int unsigned tmo,
                                              input logic [7:0] r0, input logic [7:0] r1,
                                              input logic [7:0] r2);
        logic [7:0] v;
        if (!ref_ok(dly, tmo)) return {1'b1, 8'h00};
        if (PASSES == 1) return {1'b0, r0};
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = int'(r0[b]) + int'(r1[b]) + int'(r2[b]);
            v[b] = (ones >= 2);
        end
        return {1'b0, v};
    endfunction

    task automatic run_request(input bit which, input logic [7:0] ch,
                               output int unsigned rst_cyc, output int unsigned run_cyc,
                               output int unsigned rst_falls, output bit chal_ok,
                               output bit last_en, output bit got);
        int n;
        bit seen_en;
        logic prev_rst;
        sel = which;
        rst_cyc = 0; run_cyc = 0; rst_falls = 0; chal_ok = 1'b1; last_en = 1'b0;
        got = 1'b0; seen_en = 1'b0; prev_rst = 1'b1;
        if (which) b_pass = 0; else a_pass = 0;
        @(negedge clk);
        n = 0;
        while (!o_req_ready && n < 100) begin @(negedge clk); n++; end
        req_challenge = ch;
        if (which) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        n = 0;
        while (!o_resp_valid && n < 5000) begin
            if (o_puf_enable) begin seen_en = 1'b1; run_cyc++; end
            else if (o_puf_reset && !seen_en) rst_cyc++;
            if (prev_rst && !o_puf_reset) rst_falls++;
            prev_rst = o_puf_reset;
            last_en = o_puf_enable;
            if (o_puf_challenge !== ch) chal_ok = 1'b0;
            @(negedge clk); n++;
        end
        got = o_resp_valid;
    endtask

    task automatic take_response();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_data !== 8'h00) begin errors++; $display("FAIL reset resp_data: got %h expected 00", a_resp_data); end
        checks++; if (a_resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err: got %b expected 0", a_resp_err); end
        checks++; if (a_puf_enable !== 1'b0) begin errors++; $display("FAIL reset puf_enable: got %b expected 0", a_puf_enable); end
        checks++; if (a_puf_reset !== 1'b1) begin errors++; $display("FAIL reset puf_reset: got %b expected 1", a_puf_reset); end
        checks++; if (a_puf_challenge !== 8'h00) begin errors++; $display("FAIL reset puf_challenge: got %h expected 00", a_puf_challenge); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int unsigned rc, rn, rf; bit ok, le, got; logic [8:0] exp;
        a_dly = 100; a_rsp = '{8'h3C, 8'h3C, 8'h3C};
        exp = ref_result(100, NEVER, 8'h3C, 8'h3C, 8'h3C);
        run_request(1'b0, 8'hA5, rc, rn, rf, ok, le, got);
        checks++; if (!got) begin errors++; $display("FAIL basic resp_valid: got 0 expected 1"); end
        checks++; if (a_resp_data !== exp[7:0] || a_resp_err !== exp[8]) begin errors++; $display("FAIL basic result: got err=%b data=%h expected err=%b data=%h", a_resp_err, a_resp_data, exp[8], exp[7:0]); end
        checks++; if (rc != 4) begin errors++; $display("FAIL basic puf_reset cycles: got %0d expected 4", rc); end
        checks++; if (rn != ref_run_len(100, NEVER)) begin errors++; $display("FAIL basic run cycles: got %0d expected %0d", rn, ref_run_len(100, NEVER)); end
        checks++; if (rf != PASSES) begin errors++; $display("FAIL basic reset pulses: got %0d expected %0d", rf, PASSES); end
        checks++; if (!ok) begin errors++; $display("FAIL basic puf_challenge: got unstable/%h expected a5", a_puf_challenge); end
        take_response();
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL basic return idle: got valid=%b ready=%b expected 0 1", a_resp_valid, a_req_ready); end
    endtask

    task automatic test_timeout();
        int unsigned rc, rn, rf; bit ok, le, got;
        b_dly = NEVER;
        run_request(1'b1, 8'h11, rc, rn, rf, ok, le, got);
        checks++; if (!got) begin errors++; $display("FAIL timeout resp_valid: got 0 expected 1"); end
        checks++; if (b_resp_err !== 1'b1 || b_resp_data !== 8'h00) begin errors++; $display("FAIL timeout result: got err=%b data=%h expected err=1 data=00", b_resp_err, b_resp_data); end
        checks++; if (rn != 50) begin errors++; $display("FAIL timeout run cycles: got %0d expected 50", rn); end
        checks++; if (!le) begin errors++; $display("FAIL timeout latency: got gap after RUN expected resp_valid right after RUN"); end
        checks++; if (rc != 4) begin errors++; $display("FAIL timeout puf_reset cycles: got %0d expected 4", rc); end
        take_response();
    endtask

    task automatic test_hold();
        int unsigned rc, rn, rf; bit ok, le, got; logic [7:0] r; logic [8:0] exp;
        r = 8'($urandom);
        a_dly = 10; a_rsp = '{r, r, r};
        exp = ref_result(10, NEVER, r, r, r);
        run_request(1'b0, 8'h96, rc, rn, rf, ok, le, got);
        checks++; if (!got) begin errors++; $display("FAIL hold resp_valid: got 0 expected 1"); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin req_challenge = 8'h5A; a_req_valid = 1'b1; end
            checks++;
            if (a_resp_valid !== 1'b1 || a_resp_data !== exp[7:0] || a_req_ready !== 1'b0 || a_puf_challenge !== 8'h96) begin
                errors++;
                $display("FAIL hold cycle %0d: got valid=%b data=%h ready=%b chal=%h expected 1 %h 0 96", i, a_resp_valid, a_resp_data, a_req_ready, a_puf_challenge, exp[7:0]);
            end
            @(negedge clk);
        end
        a_req_valid = 1'b0;
        take_response();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_req_ready !== 1'b1 || a_puf_enable !== 1'b0 || a_puf_reset !== 1'b1) begin
                errors++; $display("FAIL hold ignored request: got ready=%b en=%b rst=%b expected 1 0 1", a_req_ready, a_puf_enable, a_puf_reset);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        int n; bit bad_valid, bad_en;
        a_dly = 60; a_pass = 0; sel = 1'b0;
        @(negedge clk);
        req_challenge = 8'h77; a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (!a_puf_enable && n < 50) begin @(negedge clk); n++; end
        checks++; if (!a_puf_enable) begin errors++; $display("FAIL midrun reach RUN: got enable=0 expected 1"); end
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (a_puf_enable !== 1'b0 || a_puf_reset !== 1'b1) begin errors++; $display("FAIL midrun puf pins: got en=%b rst=%b expected 0 1", a_puf_enable, a_puf_reset); end
        checks++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin errors++; $display("FAIL midrun handshake: got ready=%b valid=%b expected 1 0", a_req_ready, a_resp_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        bad_valid = 1'b0; bad_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_resp_valid) bad_valid = 1'b1;
            if (a_puf_enable) bad_en = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad_valid || bad_en) begin errors++; $display("FAIL midrun after reset: got valid_seen=%b enable_seen=%b expected 0 0", bad_valid, bad_en); end
    endtask

    task automatic test_same_cycle();
        int unsigned rc, rn, rf; bit ok, le, got; logic [8:0] exp;
        for (int k = 0; k < 2; k++) begin
            b_dly = (k == 0) ? 47 : 48;
            b_rsp = '{8'hC3, 8'hC3, 8'hC3};
            exp = ref_result(b_dly, TO_B, 8'hC3, 8'hC3, 8'hC3);
            run_request(1'b1, 8'h3E, rc, rn, rf, ok, le, got);
            checks++; if (!got) begin errors++; $display("FAIL same_cycle %0d resp_valid: got 0 expected 1", k); end
            checks++; if (b_resp_err !== exp[8] || b_resp_data !== exp[7:0]) begin errors++; $display("FAIL same_cycle %0d result: got err=%b data=%h expected err=%b data=%h", k, b_resp_err, b_resp_data, exp[8], exp[7:0]); end
            checks++; if (rn != ref_run_len(b_dly, TO_B)) begin errors++; $display("FAIL same_cycle %0d run cycles: got %0d expected %0d", k, rn, ref_run_len(b_dly, TO_B)); end
            take_response();
        end
    endtask

    task automatic test_random();
        int unsigned rc, rn, rf, d; bit ok, le, got, w; logic [7:0] r0, r1, r2, ch; logic [8:0] exp;
        logic [7:0] od; logic oe;
        for (int i = 0; i < 12; i++) begin
            w  = (i % 2 == 1);
            d  = w ? $urandom_range(30, 60) : $urandom_range(3, 200);
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); ch = 8'($urandom);
            if (w) begin b_dly = d; b_rsp = '{r0, r1, r2}; end
            else begin a_dly = d; a_rsp = '{r0, r1, r2}; end
            exp = ref_result(d, w ? TO_B : NEVER, r0, r1, r2);
            run_request(w, ch, rc, rn, rf, ok, le, got);
            od = o_resp_data; oe = o_resp_err;
            checks++; if (!got) begin errors++; $display("FAIL random %0d resp_valid: got 0 expected 1", i); end
            checks++; if (oe !== exp[8] || od !== exp[7:0]) begin errors++; $display("FAIL random %0d result (dly %0d): got err=%b data=%h expected err=%b data=%h", i, d, oe, od, exp[8], exp[7:0]); end
            checks++; if (rn != ref_run_len(d, w ? TO_B : NEVER)) begin errors++; $display("FAIL random %0d run cycles: got %0d expected %0d", i, rn, ref_run_len(d, w ? TO_B : NEVER)); end
            checks++; if (!ok || rc != 4) begin errors++; $display("FAIL random %0d clear/challenge: got rst_cyc=%0d chal_ok=%b expected 4 1", i, rc, ok); end
            take_response();
        end
    endtask

`ifdef PUF_MAJORITY_VOTE_EN
    task automatic test_majority();
        int unsigned rc, rn, rf; bit ok, le, got;
        a_dly = 20; a_rsp = '{8'hF0, 8'hF1, 8'h70};
        run_request(1'b0, 8'h42, rc, rn, rf, ok, le, got);
        checks++; if (!got || a_resp_data !== 8'hF0 || a_resp_err !== 1'b0) begin errors++; $display("FAIL majority result: got valid=%b err=%b data=%h expected 1 0 f0", got, a_resp_err, a_resp_data); end
        checks++; if (rf != 3) begin errors++; $display("FAIL majority reset pulses: got %0d expected 3", rf); end
        take_response();
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_hold();
        test_reset_mid_run();
        test_same_cycle();
        test_random();
`ifdef PUF_MAJORITY_VOTE_EN
        test_majority();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_host_ctrl.md
PUF_HOST_CTRL -- requirements
Module: puf_host_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4, number of cycles puf_reset is held high before each evaluation (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2^24, maximum cycles spent in RUN before aborting (legal range 2..2^32-1).
REQ-003 SHALL have port clk, input, 1, the single system clock; all flops use its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, the host requests one evaluation.
REQ-006 SHALL have port req_challenge, input, 8, the challenge for the request.
REQ-007 SHALL have port req_ready, output, 1, the block can accept a request.
REQ-008 SHALL have port resp_valid, output, 1, a result is presented.
REQ-009 SHALL have port resp_data, output, 8, the PUF response.
REQ-010 SHALL have port resp_err, output, 1, the evaluation timed out.
REQ-011 SHALL have port resp_ready, input, 1, the host accepts the result.
REQ-012 SHALL have port puf_enable, output, 1, the ring-oscillator/counter enable to the PUF.
REQ-013 SHALL have port puf_challenge, output, 8, the challenge driven to the PUF.
REQ-014 SHALL have port puf_reset, output, 1, active-high counter/arbiter reset to the PUF.
REQ-015 SHALL have port puf_done, input, 1, the PUF all-done flag, asynchronous to clk.
REQ-016 SHALL have port puf_response, input, 8, the PUF response bits, asynchronous to clk.

Function
REQ-017 SHALL implement states IDLE, CLEAR, RUN, CAPTURE and RESP.
REQ-018 SHALL assert req_ready only in IDLE, and a request SHALL be accepted on a cycle where req_valid and req_ready are both 1.
REQ-019 SHALL, on acceptance, register req_challenge into puf_challenge, hold it stable until the next acceptance, and move to CLEAR.
REQ-020 SHALL, in CLEAR, drive puf_reset=1 and puf_enable=0 for exactly RESET_CYCLES cycles, then move to RUN.
REQ-021 SHALL, in RUN, drive puf_reset=0 and puf_enable=1, and increment a 32-bit timer starting from 0.
REQ-022 SHALL pass puf_done through a 2-flop synchronizer before any use.
REQ-023 SHALL move from RUN to CAPTURE on the first cycle synchronized done is 1.
REQ-024 SHALL, if the timer reaches TIMEOUT_CYCLES-1 without synchronized done, move to RESP with resp_err=1 and resp_data=8'h00.
REQ-025 SHALL give synchronized done priority when done and timeout occur on the same cycle.
REQ-026 SHALL, in CAPTURE, sample puf_response into resp_data with resp_err=0, deassert puf_enable, and move to RESP; puf_response is stable once done is set.
REQ-027 SHALL, in RESP, hold resp_valid=1 with resp_data and resp_err unchanged until resp_ready=1, then return to IDLE on the next cycle.
REQ-028 SHALL keep puf_enable=0 in every state except RUN and, when evaluations are repeated, between RUN passes.
REQ-029 SHALL leave puf_reset=1 in IDLE so the PUF counters stay cleared while unused.

Reset
REQ-030 SHALL, on reset_n=0, asynchronously go to IDLE with req_ready=1, resp_valid=0, resp_data=0, resp_err=0, puf_enable=0, puf_reset=1, puf_challenge=0, the timer=0 and the synchronizer flops=0.
REQ-031 SHALL abandon any in-flight evaluation on reset mid-operation and SHALL not produce a response for it.

Configuration
REQ-032 SHALL, with macro PUF_MAJORITY_VOTE_EN defined, run the CLEAR, RUN, CAPTURE sequence three times per request using the same challenge, and return the bitwise majority of the three captures.
REQ-033 SHALL, when PUF_MAJORITY_VOTE_EN is defined, report resp_err=1 and resp_data=0 if any of the three passes times out.
REQ-034 SHALL, with PUF_MAJORITY_VOTE_EN undefined, perform a single pass and contain no vote storage.

Structure
REQ-035 SHALL place the state enum and the default constants for RESET_CYCLES and TIMEOUT_CYCLES in the shared package puf_host_pkg.
REQ-036 SHALL implement the done synchronizer as sub-module puf_done_sync (parameterless, 2 flops, async active-low reset).

Verification
REQ-037 SHALL cover: challenge 8'hA5 accepted, PUF model raises done 100 cycles after enable with response 8'h3C -> resp_valid=1, resp_data=8'h3C, resp_err=0, and puf_reset high for exactly 4 cycles.
REQ-038 SHALL cover: TIMEOUT_CYCLES=50 with done never raised -> resp_valid=1, resp_err=1 and resp_data=0 exactly 50 RUN cycles after CLEAR ends.
REQ-039 SHALL cover: resp_ready held low for 20 cycles -> resp_valid and resp_data stable throughout, req_ready=0, and a new req_valid ignored.
REQ-040 SHALL cover: reset_n pulsed low mid-RUN -> puf_enable=0, puf_reset=1 and req_ready=1 immediately, with no resp_valid afterwards.
REQ-041 SHALL cover, with PUF_MAJORITY_VOTE_EN defined: passes return 8'hF0, 8'hF1 and 8'h70 -> resp_data=8'hF0, with three puf_reset pulses observed.
REQ-042 SHALL cover: done and timeout arriving on the same cycle -> resp_err=0 and the captured response is returned.
